// File: rtl/mem_access_stage.sv
// RV32I memory stage. It issues loads and stores on a req/gnt/rvalid data bus and holds the MEM->WB register.
// Latency, aligned op to WB register: store 2 edges, load 3 edges. Each gnt or rvalid wait cycle adds one edge.
// Backpressure: o_Stall_1 holds all upstream stages from the accept cycle until the completion cycle, where it drops.
// Ports:
//   clk, rstn                         : clock; asynchronous active-low reset
//   i_Valid_1 .. i_AluResult_32       : instruction controls and operands coming from the ALU stage
//   o_Stall_1                         : freezes the upstream pipeline registers
//   o_Dmem*/i_Dmem*                   : data-memory bus (req/gnt request phase, then rvalid response phase)
//   o_WbValid_1, o_WbData_32          : registered WB-stage result
//   o_Misaligned_1                    : registered one-cycle pulse for a misaligned or illegal access
module mem_access_stage (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_Valid_1,
  input  logic        i_Load_1,
  input  logic        i_Store_1,
  input  logic        i_LoadUnsigned_1,
  input  logic [1:0]  i_LoadStoreWidth_2,
  input  logic [31:0] i_Addr_32,
  input  logic [31:0] i_StoreData_32,
  input  logic [31:0] i_AluResult_32,
  output logic        o_Stall_1,
  output logic        o_DmemReq_1,
  output logic        o_DmemWe_1,
  output logic [31:0] o_DmemAddr_32,
  output logic [3:0]  o_DmemWstrb_4,
  output logic [31:0] o_DmemWdata_32,
  input  logic        i_DmemGnt_1,
  input  logic        i_DmemRvalid_1,
  input  logic [31:0] i_DmemRdata_32,
  output logic        o_WbValid_1,
  output logic [31:0] o_WbData_32,
  output logic        o_Misaligned_1
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        memop_in, misaligned_in, start_in, done_now;
  logic [3:0]  strb_in;
  logic [31:0] wdata_in;

  // Transaction context. It is captured at accept so the bus stays stable whatever upstream does.
  logic        cap_load, cap_unsigned;
  logic [1:0]  cap_width, cap_lane;
  logic [29:0] cap_word;
  logic [3:0]  cap_wstrb;
  logic [31:0] cap_wdata;

  logic [15:0] rdata_sh;
  logic [31:0] load_data;
  logic        wb_valid, misaligned_q;
  logic [31:0] wb_data;

  assign memop_in = i_Valid_1 & (i_Load_1 | i_Store_1);

  always_comb begin
    misaligned_in = 1'b0;
    case (i_LoadStoreWidth_2)
      2'b01:   misaligned_in = i_Addr_32[0];
      2'b10:   misaligned_in = |i_Addr_32[1:0];
      2'b11:   misaligned_in = 1'b1;
      default: misaligned_in = 1'b0;
    endcase
  end

  assign start_in = (state == IDLE) & memop_in & ~misaligned_in;

  // Store lane formatting. Load wins when both load and store are set, so it gets no strobes.
  always_comb begin
    strb_in  = 4'b1111;
    wdata_in = i_StoreData_32;
    case (i_LoadStoreWidth_2)
      2'b00: begin
        strb_in  = 4'b0001 << i_Addr_32[1:0];
        wdata_in = {4{i_StoreData_32[7:0]}};
      end
      2'b01: begin
        strb_in  = i_Addr_32[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{i_StoreData_32[15:0]}};
      end
      default: begin
        strb_in  = 4'b1111;
        wdata_in = i_StoreData_32;
      end
    endcase
    if (i_Load_1) strb_in = 4'b0000;
  end

  always_comb begin
    state_nxt = state;
    done_now  = 1'b0;
    case (state)
      IDLE: if (start_in) state_nxt = REQ;
      REQ: begin
        if (i_DmemGnt_1) begin
          if (cap_load) begin
            state_nxt = RESP;
          end else begin
            state_nxt = IDLE;
            done_now  = 1'b1;
          end
        end
      end
      RESP: begin
        if (i_DmemRvalid_1) begin
          state_nxt = IDLE;
          done_now  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stall drops in the completion cycle, so upstream advances on the same edge that WB is written.
  assign o_Stall_1 = start_in | ((state != IDLE) & ~done_now);

  // Load extraction. The shift moves the addressed byte or half down to bit 0.
  assign rdata_sh = 16'(i_DmemRdata_32 >> {cap_lane, 3'b000});

  always_comb begin
    case (cap_width)
      2'b00:   load_data = {{24{~cap_unsigned & rdata_sh[7]}}, rdata_sh[7:0]};
      2'b01:   load_data = {{16{~cap_unsigned & rdata_sh[15]}}, rdata_sh[15:0]};
      default: load_data = i_DmemRdata_32;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      cap_load     <= 1'b0;
      cap_unsigned <= 1'b0;
      cap_width    <= 2'b00;
      cap_lane     <= 2'b00;
      cap_word     <= 30'd0;
      cap_wstrb    <= 4'b0000;
      cap_wdata    <= 32'd0;
      wb_valid     <= 1'b0;
      wb_data      <= 32'd0;
      misaligned_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      misaligned_q <= (state == IDLE) & memop_in & misaligned_in;
      if (start_in) begin
        cap_load     <= i_Load_1;
        cap_unsigned <= i_LoadUnsigned_1;
        cap_width    <= i_LoadStoreWidth_2;
        cap_lane     <= i_Addr_32[1:0];
        cap_word     <= i_Addr_32[31:2];
        cap_wstrb    <= strb_in;
        cap_wdata    <= wdata_in;
      end
      if (state == IDLE) begin
        // Only a non-memory op completes from IDLE. Memory ops either stall or are rejected as misaligned.
        wb_valid <= i_Valid_1 & ~memop_in;
        if (i_Valid_1 & ~memop_in) wb_data <= i_AluResult_32;
      end else begin
        wb_valid <= done_now;
        if (done_now) wb_data <= cap_load ? load_data : 32'd0;
      end
    end
  end

  assign o_DmemReq_1    = (state == REQ);
  assign o_DmemWe_1     = o_DmemReq_1 & ~cap_load;
  assign o_DmemAddr_32  = o_DmemReq_1 ? {cap_word, 2'b00} : 32'd0;
  assign o_DmemWstrb_4  = o_DmemReq_1 ? cap_wstrb : 4'b0000;
  assign o_DmemWdata_32 = o_DmemReq_1 ? cap_wdata : 32'd0;
  assign o_WbValid_1    = wb_valid;
  assign o_WbData_32    = wb_data;
  assign o_Misaligned_1 = misaligned_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed steps from the test plan, then randomized operations.
// Inputs are driven just after the falling edge and outputs are sampled 1 ns later.
// Expected values come from a lane/byte-level reference model written as plain arithmetic.
module tb_mem_access_stage;

  logic        clk, rstn;
  logic        i_Valid_1, i_Load_1, i_Store_1, i_LoadUnsigned_1;
  logic [1:0]  i_LoadStoreWidth_2;
  logic [31:0] i_Addr_32, i_StoreData_32, i_AluResult_32;
  logic        o_Stall_1, o_DmemReq_1, o_DmemWe_1;
  logic [31:0] o_DmemAddr_32, o_DmemWdata_32;
  logic [3:0]  o_DmemWstrb_4;
  logic        i_DmemGnt_1, i_DmemRvalid_1;
  logic [31:0] i_DmemRdata_32;
  logic        o_WbValid_1, o_Misaligned_1;
  logic [31:0] o_WbData_32;

  int total = 0;
  int bad = 0;
  int req_cnt = 0;

  mem_access_stage dut (
    .clk(clk), .rstn(rstn),
    .i_Valid_1(i_Valid_1), .i_Load_1(i_Load_1), .i_Store_1(i_Store_1),
    .i_LoadUnsigned_1(i_LoadUnsigned_1), .i_LoadStoreWidth_2(i_LoadStoreWidth_2),
    .i_Addr_32(i_Addr_32), .i_StoreData_32(i_StoreData_32), .i_AluResult_32(i_AluResult_32),
    .o_Stall_1(o_Stall_1), .o_DmemReq_1(o_DmemReq_1), .o_DmemWe_1(o_DmemWe_1),
    .o_DmemAddr_32(o_DmemAddr_32), .o_DmemWstrb_4(o_DmemWstrb_4), .o_DmemWdata_32(o_DmemWdata_32),
    .i_DmemGnt_1(i_DmemGnt_1), .i_DmemRvalid_1(i_DmemRvalid_1), .i_DmemRdata_32(i_DmemRdata_32),
    .o_WbValid_1(o_WbValid_1), .o_WbData_32(o_WbData_32), .o_Misaligned_1(o_Misaligned_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts request cycles, which exposes lost or duplicated requests.
  always @(posedge clk) if (o_DmemReq_1) req_cnt <= req_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: an access covers bytes [off, off+size) of the word.
  function automatic logic [3:0] m_strb(input logic [1:0] w, input logic [1:0] a);
    int sz;
    int off;
    logic [3:0] s;
    sz = 1 << w;
    off = int'(a);
    s = 4'b0000;
    for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + sz);
    return s;
  endfunction

  // Each lane carries the store byte that lands in that lane when the value is repeated across the word.
  function automatic logic [31:0] m_wdata(input logic [1:0] w, input logic [31:0] sd);
    int sz;
    logic [31:0] d;
    sz = 1 << w;
    d = 32'd0;
    for (int i = 0; i < 4; i++) d[8*i +: 8] = sd[8*(i % sz) +: 8];
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [1:0] a,
                                         input logic [1:0] w, input logic uns);
    int sz;
    longint v;
    sz = 1 << w;
    if (sz == 4) return word;
    v = longint'(word >> (8 * int'(a))) & ((64'sd1 <<< (8 * sz)) - 1);
    if (!uns && v >= (64'sd1 <<< (8 * sz - 1))) v = v - (64'sd1 <<< (8 * sz));
    return 32'(v);
  endfunction

  // An aligned memory op. It starts in the current low phase and ends in the low phase after completion, with valid dropped.
  task automatic do_mem(input logic ld, input logic st, input logic [1:0] w, input logic uns,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input int gw, input int rw, input logic [31:0] rdata);
    int r0;
    i_Valid_1 = 1'b1; i_Load_1 = ld; i_Store_1 = st; i_LoadUnsigned_1 = uns;
    i_LoadStoreWidth_2 = w; i_Addr_32 = addr; i_StoreData_32 = sd; i_AluResult_32 = $urandom;
    #1;
    chk("accept_stall", 32'(o_Stall_1), 32'd1);
    chk("accept_noreq", 32'(o_DmemReq_1), 32'd0);
    r0 = req_cnt;
    for (int k = 0; k <= gw; k++) begin
      @(negedge clk);
      i_DmemGnt_1 = (k == gw);
      #1;
      chk("req_high", 32'(o_DmemReq_1), 32'd1);
      chk("req_addr", o_DmemAddr_32, {addr[31:2], 2'b00});
      chk("req_we", 32'(o_DmemWe_1), 32'(!ld));
      chk("req_wstrb", 32'(o_DmemWstrb_4), ld ? 32'd0 : 32'(m_strb(w, addr[1:0])));
      if (!ld) chk("req_wdata", o_DmemWdata_32, m_wdata(w, sd));
      chk("req_stall", 32'(o_Stall_1), 32'(ld || (k != gw)));
    end
    @(negedge clk);
    i_DmemGnt_1 = 1'b0;
    if (ld) begin
      for (int k = 0; k <= rw; k++) begin
        if (k > 0) @(negedge clk);
        i_DmemRvalid_1 = (k == rw);
        i_DmemRdata_32 = (k == rw) ? rdata : $urandom;
        #1;
        chk("resp_noreq", 32'(o_DmemReq_1), 32'd0);
        chk("resp_stall", 32'(o_Stall_1), 32'(k != rw));
      end
      @(negedge clk);
      i_DmemRvalid_1 = 1'b0;
    end
    i_Valid_1 = 1'b0; i_Load_1 = 1'b0; i_Store_1 = 1'b0;
    #1;
    chk("wb_valid", 32'(o_WbValid_1), 32'd1);
    chk("wb_data", o_WbData_32, ld ? m_load(rdata, addr[1:0], w, uns) : 32'd0);
    chk("req_count", 32'(req_cnt - r0), 32'(gw + 1));
    chk("done_stall", 32'(o_Stall_1), 32'd0);
  endtask

  task automatic do_mis(input logic ld, input logic st, input logic [1:0] w, input logic [31:0] addr);
    int r0;
    i_Valid_1 = 1'b1; i_Load_1 = ld; i_Store_1 = st; i_LoadUnsigned_1 = 1'b0;
    i_LoadStoreWidth_2 = w; i_Addr_32 = addr; i_StoreData_32 = $urandom;
    r0 = req_cnt;
    #1;
    chk("mis_stall", 32'(o_Stall_1), 32'd0);
    chk("mis_noreq", 32'(o_DmemReq_1), 32'd0);
    @(negedge clk);
    i_Valid_1 = 1'b0; i_Load_1 = 1'b0; i_Store_1 = 1'b0;
    #1;
    chk("mis_pulse", 32'(o_Misaligned_1), 32'd1);
    chk("mis_wbvalid", 32'(o_WbValid_1), 32'd0);
    @(negedge clk);
    #1;
    chk("mis_pulse_end", 32'(o_Misaligned_1), 32'd0);
    chk("mis_reqcount", 32'(req_cnt - r0), 32'd0);
  endtask

  task automatic do_alu(input logic [31:0] v);
    i_Valid_1 = 1'b1; i_Load_1 = 1'b0; i_Store_1 = 1'b0; i_AluResult_32 = v;
    #1;
    chk("alu_stall", 32'(o_Stall_1), 32'd0);
    chk("alu_noreq", 32'(o_DmemReq_1), 32'd0);
    @(negedge clk);
    i_Valid_1 = 1'b0;
    #1;
    chk("alu_wbvalid", 32'(o_WbValid_1), 32'd1);
    chk("alu_wbdata", o_WbData_32, v);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(o_Stall_1), 32'd0);
    chk({tag, "_req"}, 32'(o_DmemReq_1), 32'd0);
    chk({tag, "_we"}, 32'(o_DmemWe_1), 32'd0);
    chk({tag, "_addr"}, o_DmemAddr_32, 32'd0);
    chk({tag, "_wstrb"}, 32'(o_DmemWstrb_4), 32'd0);
    chk({tag, "_wdata"}, o_DmemWdata_32, 32'd0);
    chk({tag, "_wbvalid"}, 32'(o_WbValid_1), 32'd0);
    chk({tag, "_wbdata"}, o_WbData_32, 32'd0);
    chk({tag, "_mis"}, 32'(o_Misaligned_1), 32'd0);
  endtask

  initial begin
    logic [1:0]  w;
    logic [31:0] addr;
    logic        ld, st;
    int          kind;

    rstn = 1'b1;
    i_Valid_1 = 1'b0; i_Load_1 = 1'b0; i_Store_1 = 1'b0; i_LoadUnsigned_1 = 1'b0;
    i_LoadStoreWidth_2 = 2'b00; i_Addr_32 = 32'd0; i_StoreData_32 = 32'd0; i_AluResult_32 = 32'd0;
    i_DmemGnt_1 = 1'b0; i_DmemRvalid_1 = 1'b0; i_DmemRdata_32 = 32'd0;
    #2 rstn = 1'b0;
    #1 chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // SB at 0x1003 with an immediate grant.
    do_mem(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'hAABB_CC5A, 0, 0, 32'd0);
    chk("sb_const", o_WbData_32, 32'd0);
    // LH signed with a delayed grant and a delayed rvalid, then LHU of the same word.
    do_mem(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'd0, 2, 2, 32'h8001_7FFF);
    chk("lh_const", o_WbData_32, 32'hFFFF_8001);
    do_mem(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'd0, 0, 1, 32'h8001_7FFF);
    chk("lhu_const", o_WbData_32, 32'h0000_8001);
    do_mem(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_2001, 32'd0, 1, 0, 32'h0000_F000);
    chk("lb_const", o_WbData_32, 32'hFFFF_FFF0);
    do_mem(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_2001, 32'd0, 0, 0, 32'h0000_F000);
    chk("lbu_const", o_WbData_32, 32'h0000_00F0);
    do_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_2000, 32'd0, 0, 0, 32'h0000_F000);
    chk("lw_const", o_WbData_32, 32'h0000_F000);
    @(negedge clk);
    // Misaligned LW and SH, plus the illegal width.
    do_mis(1'b1, 1'b0, 2'b10, 32'h0000_3002);
    do_mis(1'b0, 1'b1, 2'b01, 32'h0000_3001);
    do_mis(1'b0, 1'b1, 2'b11, 32'h0000_3000);
    // ALU pass-through, then SW and LW back to back.
    do_alu(32'h0000_1234);
    do_mem(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'hCAFE_F00D, 1, 0, 32'd0);
    do_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'd0, 0, 1, 32'h1357_9BDF);
    // Load and store both set: the op behaves as a load.
    do_mem(1'b1, 1'b1, 2'b01, 1'b1, 32'h0000_4006, 32'h1111_2222, 0, 0, 32'hBEEF_0000);

    // Reset while a load waits in RESP.
    @(negedge clk);
    i_Valid_1 = 1'b1; i_Load_1 = 1'b1; i_Store_1 = 1'b0; i_LoadStoreWidth_2 = 2'b10; i_Addr_32 = 32'h0000_5000;
    @(negedge clk);
    i_DmemGnt_1 = 1'b1;
    @(negedge clk);
    i_DmemGnt_1 = 1'b0;
    #1 chk("rst_pre_stall", 32'(o_Stall_1), 32'd1);
    rstn = 1'b0; i_Valid_1 = 1'b0; i_Load_1 = 1'b0;
    #1 chk_all_zero("midrst");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    i_DmemRvalid_1 = 1'b1; i_DmemRdata_32 = 32'hDEAD_BEEF;
    #1;
    chk("late_rv_stall", 32'(o_Stall_1), 32'd0);
    chk("late_rv_req", 32'(o_DmemReq_1), 32'd0);
    @(negedge clk);
    i_DmemRvalid_1 = 1'b0;
    #1;
    chk("late_rv_wbvalid", 32'(o_WbValid_1), 32'd0);
    chk("late_rv_wbdata", o_WbData_32, 32'd0);
    do_mem(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_5004, 32'h0BAD_F00D, 0, 0, 32'd0);

    // Randomized mix of operations, wait states and idle gaps.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      w = 2'($urandom_range(0, 2));
      addr = $urandom;
      if (kind < 2) begin
        do_alu($urandom);
      end else if (kind < 3) begin
        if (w == 2'b00) w = 2'b11;
        else if (w == 2'b01) addr[0] = 1'b1;
        else addr[1:0] = 2'($urandom_range(1, 3));
        ld = 1'($urandom_range(0, 1));
        do_mis(ld, ~ld, w, addr);
      end else begin
        if (w == 2'b01) addr[0] = 1'b0;
        if (w == 2'b10) addr[1:0] = 2'b00;
        ld = 1'($urandom_range(0, 1));
        st = ld ? 1'($urandom_range(0, 1)) : 1'b1;
        do_mem(ld, st, w, 1'($urandom_range(0, 1)), addr, $urandom,
               $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
